// File: rtl/pic_seq_pkg.sv
// pic_seq_pkg: shared types and helpers for the PIC cascade sequencer.
//   state_t     - sequencer FSM states
//   wr_tgt_t    - write target: {MASTER, SLAVE} x {ICW1, ICW2_4}
//   ICW1_*      - bit positions inside ICW1
//   slot_*      - helpers for the 8-entry write list
//                 (slots 0..3 = master ICW1..4, slots 4..7 = slave ICW1..4)
package pic_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_GAP, S_READY,
    S_ACK1_LO, S_ACK1_HI, S_ACK2_LO, S_ACK2_HI
  } state_t;

  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;

  typedef enum logic [1:0] {
    T_M_ICW1   = 2'b00,
    T_M_ICW2_4 = 2'b01,
    T_S_ICW1   = 2'b10,
    T_S_ICW2_4 = 2'b11
  } wr_tgt_t;

  // Slot bit 2 selects slave; any slot other than ICW1 goes to the ICW2_4 strobe.
  function automatic wr_tgt_t slot_target(input logic [2:0] slot);
    return wr_tgt_t'({slot[2], slot[1:0] != 2'd0});
  endfunction

  // Which slots are actually written, derived from the two ICW1 values.
  function automatic logic [7:0] slot_valid(input logic [7:0] m_icw1,
                                            input logic [7:0] s_icw1);
    logic [7:0] v;
    v[0] = 1'b1;
    v[1] = 1'b1;
    v[2] = ~m_icw1[ICW1_SNGL];
    v[3] = m_icw1[ICW1_IC4];
    v[4] = 1'b1;
    v[5] = 1'b1;
    v[6] = ~s_icw1[ICW1_SNGL];
    v[7] = s_icw1[ICW1_IC4];
    // Single-mode master has no slave behind it.
    if (m_icw1[ICW1_SNGL]) v[7:4] = 4'b0000;
    return v;
  endfunction

  // First valid slot after cur; returns {found, slot}.
  function automatic logic [3:0] next_slot(input logic [2:0] cur,
                                           input logic [7:0] valid);
    logic [3:0] r;
    r = 4'b0000;
    for (int j = 7; j >= 0; j--)
      if (j > int'(cur) && valid[j]) r = {1'b1, 3'(j)};
    return r;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pic_seq_timer.sv
// pic_seq_timer: loadable down-counter shared by the WR, GAP and ACK states.
//   clk, rst  - clock, async active-high reset
//   load      - load load_val this cycle (asserted on every state entry)
//   load_val  - phase length minus one
//   done      - counter has reached zero (last cycle of the phase)
// The counter stops at zero rather than wrapping.
module pic_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/pic_cascade_sequencer.sv
// pic_cascade_sequencer: programs ICW1-ICW4 into a master/slave PIC pair over a
// shared data bus, then answers master INT with a two-pulse INTA (ack_n) cycle
// and captures the vector.
//   clk, rst          - clock, async active-high reset
//   start             - (re)initialise; honoured in IDLE and READY
//   master_int        - master PIC INT
//   ctrl_logic_data   - master vector output
//   data_bus          - shared internal bus to both PICs
//   m_/s_wr_icw1      - ICW1 write strobes
//   m_/s_wr_icw2_4    - ICW2/3/4 write strobes
//   ack_n             - INTA to both PICs, active low
//   vector            - last captured vector
//   vector_valid      - one-cycle pulse when vector updates
//   init_done         - both PICs programmed
//   busy              - sequencing writes or an INTA cycle
// All outputs are registered from the current state, so they appear one cycle
// after the state is entered.
module pic_cascade_sequencer
  import pic_seq_pkg::*;
#(
  parameter logic [7:0] M_ICW1 = 8'h01,
  parameter logic [7:0] M_ICW2 = 8'hA8,
  parameter logic [7:0] M_ICW3 = 8'h04,
  parameter logic [7:0] M_ICW4 = 8'h03,
  parameter logic [7:0] S_ICW1 = 8'h01,
  parameter logic [7:0] S_ICW2 = 8'hA8,
  parameter logic [7:0] S_ICW3 = 8'h02,
  parameter logic [7:0] S_ICW4 = 8'h03,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 1,
  parameter int ACK_LOW       = 2,
  parameter int ACK_HIGH      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       master_int,
  input  logic [7:0] ctrl_logic_data,
  output logic [7:0] data_bus,
  output logic       m_wr_icw1,
  output logic       m_wr_icw2_4,
  output logic       s_wr_icw1,
  output logic       s_wr_icw2_4,
  output logic       ack_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       init_done,
  output logic       busy
);

  localparam int MAXC = max4(STROBE_CYCLES, GAP_CYCLES, ACK_LOW, ACK_HIGH);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] LD_STB = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] LD_GAP = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LD_LO  = CW'(ACK_LOW - 1);
  localparam logic [CW-1:0] LD_HI  = CW'(ACK_HIGH - 1);

  // Write-list ROM: data per slot plus valid bits.
  localparam logic [7:0][7:0] WDATA = {S_ICW4, S_ICW3, S_ICW2, S_ICW1,
                                       M_ICW4, M_ICW3, M_ICW2, M_ICW1};
  localparam logic [7:0]      WVALID = slot_valid(M_ICW1, S_ICW1);

  state_t        state, state_nxt;
  logic [2:0]    slot;
  logic [3:0]    nxt;
  wr_tgt_t       tgt;
  logic          tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;

  assign nxt = next_slot(slot, WVALID);
  assign tgt = slot_target(slot);

  pic_seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state and timer reload on each state entry.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      S_IDLE:
        if (start) begin
          state_nxt = S_WR; tmr_load = 1'b1; tmr_val = LD_STB;
        end
      S_READY:
        if (start) begin
          state_nxt = S_WR; tmr_load = 1'b1; tmr_val = LD_STB;
        end else if (master_int) begin
          state_nxt = S_ACK1_LO; tmr_load = 1'b1; tmr_val = LD_LO;
        end
      S_WR:
        if (tmr_done) begin
          state_nxt = S_GAP; tmr_load = 1'b1; tmr_val = LD_GAP;
        end
      S_GAP:
        if (tmr_done) begin
          if (nxt[3]) begin
            state_nxt = S_WR; tmr_load = 1'b1; tmr_val = LD_STB;
          end else begin
            state_nxt = S_READY;
          end
        end
      S_ACK1_LO:
        if (tmr_done) begin
          state_nxt = S_ACK1_HI; tmr_load = 1'b1; tmr_val = LD_HI;
        end
      S_ACK1_HI:
        if (tmr_done) begin
          state_nxt = S_ACK2_LO; tmr_load = 1'b1; tmr_val = LD_LO;
        end
      S_ACK2_LO:
        if (tmr_done) begin
          state_nxt = S_ACK2_HI; tmr_load = 1'b1; tmr_val = LD_HI;
        end
      S_ACK2_HI:
        if (tmr_done) state_nxt = S_READY;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      slot         <= '0;
      data_bus     <= '0;
      m_wr_icw1    <= 1'b0;
      m_wr_icw2_4  <= 1'b0;
      s_wr_icw1    <= 1'b0;
      s_wr_icw2_4  <= 1'b0;
      ack_n        <= 1'b1;
      vector       <= '0;
      vector_valid <= 1'b0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == S_IDLE || state == S_READY) && start)
        slot <= '0;
      else if (state == S_GAP && tmr_done && nxt[3])
        slot <= nxt[2:0];

      data_bus    <= (state == S_WR || state == S_GAP) ? WDATA[slot] : 8'h00;
      m_wr_icw1   <= (state == S_WR) && (tgt == T_M_ICW1);
      m_wr_icw2_4 <= (state == S_WR) && (tgt == T_M_ICW2_4);
      s_wr_icw1   <= (state == S_WR) && (tgt == T_S_ICW1);
      s_wr_icw2_4 <= (state == S_WR) && (tgt == T_S_ICW2_4);

      ack_n <= !(state == S_ACK1_LO || state == S_ACK2_LO);

      // Vector is taken on the last low cycle of the second INTA pulse.
      vector_valid <= 1'b0;
      if (state == S_ACK2_LO && tmr_done) begin
        vector       <= ctrl_logic_data;
        vector_valid <= 1'b1;
      end

      // Sticky through INTA cycles; cleared once re-initialisation starts.
      if (state == S_READY)   init_done <= 1'b1;
      else if (state == S_WR) init_done <= 1'b0;

      busy <= !(state == S_IDLE || state == S_READY);
    end
  end

endmodule

// File: tb/tb_pic_cascade_sequencer.sv
module tb_pic_cascade_sequencer;

  localparam logic [7:0] M1 = 8'h01, M2 = 8'hA8, M3 = 8'h04, M4 = 8'h03;
  localparam logic [7:0] S1 = 8'h01, S2 = 8'hA8, S3 = 8'h02, S4 = 8'h03;
  localparam int STB = 1, GAP = 1, LO = 2, HI = 2;

  logic       clk = 1'b0;
  logic       rst, start, master_int, b_start;
  logic [7:0] cld;

  logic [7:0] data_bus, vector;
  logic       m_wr_icw1, m_wr_icw2_4, s_wr_icw1, s_wr_icw2_4;
  logic       ack_n, vector_valid, init_done, busy;

  logic [7:0] b_data_bus, b_vector;
  logic       b_m_wr_icw1, b_m_wr_icw2_4, b_s_wr_icw1, b_s_wr_icw2_4;
  logic       b_ack_n, b_vector_valid, b_init_done, b_busy;

  always #5 clk = ~clk;

  pic_cascade_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .master_int(master_int),
    .ctrl_logic_data(cld), .data_bus(data_bus),
    .m_wr_icw1(m_wr_icw1), .m_wr_icw2_4(m_wr_icw2_4),
    .s_wr_icw1(s_wr_icw1), .s_wr_icw2_4(s_wr_icw2_4),
    .ack_n(ack_n), .vector(vector), .vector_valid(vector_valid),
    .init_done(init_done), .busy(busy)
  );

  pic_cascade_sequencer #(.M_ICW1(8'h03)) dut_sngl (
    .clk(clk), .rst(rst), .start(b_start), .master_int(1'b0),
    .ctrl_logic_data(cld), .data_bus(b_data_bus),
    .m_wr_icw1(b_m_wr_icw1), .m_wr_icw2_4(b_m_wr_icw2_4),
    .s_wr_icw1(b_s_wr_icw1), .s_wr_icw2_4(b_s_wr_icw2_4),
    .ack_n(b_ack_n), .vector(b_vector), .vector_valid(b_vector_valid),
    .init_done(b_init_done), .busy(b_busy)
  );

  typedef struct packed {
    logic [7:0] db;
    logic [3:0] stb;   // {m_icw1, m_icw2_4, s_icw1, s_icw2_4}
    logic       ack_n;
    logic       vv;
    logic       init;
    logic       busy;
    logic [7:0] vec;
  } obs_t;

  typedef struct {
    logic       start;  // noise inputs, must be ignored while writing
    logic       mi;
    logic [7:0] db;     // expected bus value
    logic [3:0] stb;    // expected strobe
  } wr_vec_t;

  int checks = 0;
  int errors = 0;

  obs_t       expq[$];
  logic       m_init;
  logic [7:0] m_vec;
  obs_t       rst_obs;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic obs_t obs_a();
    obs_t o;
    o.db = data_bus;
    o.stb = {m_wr_icw1, m_wr_icw2_4, s_wr_icw1, s_wr_icw2_4};
    o.ack_n = ack_n; o.vv = vector_valid; o.init = init_done; o.busy = busy;
    o.vec = vector;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.db = b_data_bus;
    o.stb = {b_m_wr_icw1, b_m_wr_icw2_4, b_s_wr_icw1, b_s_wr_icw2_4};
    o.ack_n = b_ack_n; o.vv = b_vector_valid; o.init = b_init_done; o.busy = b_busy;
    o.vec = b_vector;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '{db: 8'h00, stb: 4'h0, ack_n: 1'b1, vv: 1'b0, init: m_init, busy: 1'b0, vec: m_vec};
    return o;
  endfunction

  // Reference model: whole expected output trace for an init run, from the write rules.
  task automatic push_init();
    logic [7:0] wd[$];
    logic [3:0] wt[$];
    logic [7:0] m1v, s1v;
    m1v = M1; s1v = S1;
    expq.push_back(idle_obs());
    wd.push_back(M1); wt.push_back(4'b1000);
    wd.push_back(M2); wt.push_back(4'b0100);
    if (!m1v[1]) begin wd.push_back(M3); wt.push_back(4'b0100); end
    if (m1v[0])  begin wd.push_back(M4); wt.push_back(4'b0100); end
    if (!m1v[1]) begin
      wd.push_back(S1); wt.push_back(4'b0010);
      wd.push_back(S2); wt.push_back(4'b0001);
      if (!s1v[1]) begin wd.push_back(S3); wt.push_back(4'b0001); end
      if (s1v[0])  begin wd.push_back(S4); wt.push_back(4'b0001); end
    end
    foreach (wd[i]) begin
      for (int c = 0; c < STB; c++)
        expq.push_back('{db: wd[i], stb: wt[i], ack_n: 1'b1, vv: 1'b0, init: 1'b0, busy: 1'b1, vec: m_vec});
      for (int c = 0; c < GAP; c++)
        expq.push_back('{db: wd[i], stb: 4'h0, ack_n: 1'b1, vv: 1'b0, init: 1'b0, busy: 1'b1, vec: m_vec});
    end
    m_init = 1'b1;
  endtask

  // Reference model: INTA cycle trace; vector shows up on the last low cycle of pulse 2.
  task automatic push_ack(input logic [7:0] v);
    expq.push_back(idle_obs());
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < LO; c++) begin
        if (p == 1 && c == LO - 1) begin
          m_vec = v;
          expq.push_back('{db: 8'h00, stb: 4'h0, ack_n: 1'b0, vv: 1'b1, init: m_init, busy: 1'b1, vec: m_vec});
        end else begin
          expq.push_back('{db: 8'h00, stb: 4'h0, ack_n: 1'b0, vv: 1'b0, init: m_init, busy: 1'b1, vec: m_vec});
        end
      end
      for (int c = 0; c < HI; c++)
        expq.push_back('{db: 8'h00, stb: 4'h0, ack_n: 1'b1, vv: 1'b0, init: m_init, busy: 1'b1, vec: m_vec});
    end
  endtask

  task automatic step(input string nm);
    obs_t e;
    @(negedge clk);
    e = (expq.size() != 0) ? expq.pop_front() : idle_obs();
    check(nm, {8'h00, obs_a()}, {8'h00, e});
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      check({nm, "_ack_idle"}, 32'(ack_n), 32'(1));
      n++;
    end
    check(nm, 32'(init_done), 32'(1));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    expq.delete(); m_init = 1'b0; m_vec = 8'h00;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_vec_t tbl[8];
    wr_vec_t tbl_b[3];
    logic [7:0] ackpat;
    logic [2:0] r;

    tbl[0] = '{start: 1'b1, mi: 1'b0, db: 8'h01, stb: 4'b1000};
    tbl[1] = '{start: 1'b0, mi: 1'b1, db: 8'hA8, stb: 4'b0100};
    tbl[2] = '{start: 1'b1, mi: 1'b1, db: 8'h04, stb: 4'b0100};
    tbl[3] = '{start: 1'b0, mi: 1'b0, db: 8'h03, stb: 4'b0100};
    tbl[4] = '{start: 1'b0, mi: 1'b1, db: 8'h01, stb: 4'b0010};
    tbl[5] = '{start: 1'b1, mi: 1'b0, db: 8'hA8, stb: 4'b0001};
    tbl[6] = '{start: 1'b0, mi: 1'b0, db: 8'h02, stb: 4'b0001};
    tbl[7] = '{start: 1'b1, mi: 1'b1, db: 8'h03, stb: 4'b0001};
    tbl_b[0] = '{start: 1'b0, mi: 1'b0, db: 8'h03, stb: 4'b1000};
    tbl_b[1] = '{start: 1'b1, mi: 1'b0, db: 8'hA8, stb: 4'b0100};
    tbl_b[2] = '{start: 1'b0, mi: 1'b0, db: 8'h03, stb: 4'b0100};
    rst_obs = '{db: 8'h00, stb: 4'h0, ack_n: 1'b1, vv: 1'b0, init: 1'b0, busy: 1'b0, vec: 8'h00};

    rst = 1'b1; start = 1'b0; master_int = 1'b0; b_start = 1'b0; cld = 8'h00;
    m_init = 1'b0; m_vec = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_a", {8'h00, obs_a()}, {8'h00, rst_obs});
    check("reset_b", {8'h00, obs_b()}, {8'h00, rst_obs});
    rst = 1'b0;

    // INT in IDLE is ignored.
    master_int = 1'b1; cld = 8'h77;
    @(negedge clk); master_int = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_int_ignored", {8'h00, obs_a()}, {8'h00, rst_obs});

    // Full default init, table-driven, with ignored start/int noise.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("init_pre_busy", 32'(busy), 32'(0));
    for (int k = 0; k < 8; k++) begin
      start = tbl[k].start; master_int = tbl[k].mi;
      @(negedge clk);
      start = 1'b0; master_int = 1'b0;
      check("wr_db", 32'(data_bus), 32'(tbl[k].db));
      check("wr_stb", 32'({m_wr_icw1, m_wr_icw2_4, s_wr_icw1, s_wr_icw2_4}), 32'(tbl[k].stb));
      check("wr_busy", 32'(busy), 32'(1));
      @(negedge clk);
      check("gap_db", 32'(data_bus), 32'(tbl[k].db));
      check("gap_stb", 32'({m_wr_icw1, m_wr_icw2_4, s_wr_icw1, s_wr_icw2_4}), 32'(0));
    end
    check("init_done_n16", 32'(init_done), 32'(0));
    @(negedge clk);
    check("init_done_n17", 32'(init_done), 32'(1));
    check("ready_idle_bus", {8'h00, obs_a()}, 32'({8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}));

    // Single-mode master: ICW3 and all slave writes skipped.
    b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_start = tbl_b[k].start;
      @(negedge clk);
      b_start = 1'b0;
      check("sngl_wr_db", 32'(b_data_bus), 32'(tbl_b[k].db));
      check("sngl_wr_stb", 32'({b_m_wr_icw1, b_m_wr_icw2_4, b_s_wr_icw1, b_s_wr_icw2_4}), 32'(tbl_b[k].stb));
      @(negedge clk);
      check("sngl_gap_stb", 32'({b_m_wr_icw1, b_m_wr_icw2_4, b_s_wr_icw1, b_s_wr_icw2_4}), 32'(0));
    end
    check("sngl_init_n6", 32'(b_init_done), 32'(0));
    @(negedge clk);
    check("sngl_init_n7", 32'(b_init_done), 32'(1));
    check("sngl_bus_idle", 32'(b_data_bus), 32'(0));

    // INTA cycle, vector AA; INT drops after the first pulse.
    ackpat = 8'b11001100;
    master_int = 1'b1; cld = 8'hAA;
    @(negedge clk);
    check("ack_pre", 32'(ack_n), 32'(1));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) master_int = 1'b0;
      check("ack_n_pat", 32'(ack_n), 32'(ackpat[i-1]));
      check("ack_vv", 32'(vector_valid), 32'(i == 6));
      if (i == 6) check("ack_vector", 32'(vector), 32'(8'hAA));
      check("ack_busy", 32'(busy), 32'(1));
    end
    @(negedge clk);
    check("ack_done_busy", 32'(busy), 32'(0));
    check("ack_done_init", 32'(init_done), 32'(1));
    check("ack_done_vec", 32'(vector), 32'(8'hAA));

    // start and INT together in READY: re-init wins.
    start = 1'b1; master_int = 1'b1; cld = 8'h5C;
    @(negedge clk);
    start = 1'b0; master_int = 1'b0;
    check("both_init_still", 32'(init_done), 32'(1));
    @(negedge clk);
    check("both_init_drop", 32'(init_done), 32'(0));
    check("both_ack_high", 32'(ack_n), 32'(1));
    check("both_first_wr", 32'({data_bus, m_wr_icw1}), 32'({8'h01, 1'b1}));
    wait_init("both_reinit");

    // Reset during the third write, then restart from master ICW1.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("third_wr", 32'({data_bus, m_wr_icw2_4}), 32'({8'h04, 1'b1}));
    #1 rst = 1'b1;
    #1 check("rst_mid_wr", {8'h00, obs_a()}, {8'h00, rst_obs});
    @(negedge clk); rst = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("restart_wr", 32'({data_bus, m_wr_icw1, m_wr_icw2_4}), 32'({8'h01, 2'b10}));
    wait_init("restart");

    // Reset mid-INTA: ack_n releases immediately.
    master_int = 1'b1; cld = 8'h55;
    @(negedge clk); master_int = 1'b0;
    @(negedge clk);
    check("mid_ack_low", 32'(ack_n), 32'(0));
    #1 rst = 1'b1;
    #1 check("rst_mid_ack", {8'h00, obs_a()}, {8'h00, rst_obs});
    @(negedge clk); rst = 1'b0;

    // Randomized run against the trace model.
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      step("rand");
      if (expq.size() == 0) begin
        r = 3'($urandom_range(0, 7));
        start = (r >= 3'd6);
        master_int = (r >= 3'd3) && (r != 3'd6);
        cld = 8'($urandom);
        if (start) push_init();
        else if (master_int && m_init) push_ack(cld);
      end else begin
        start = 1'($urandom);
        master_int = 1'($urandom);
      end
    end
    start = 1'b0; master_int = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
